// File: rtl/adder_result_collector.sv
// adder_result_collector: valid/ready result stage behind the pipelined adder part3.
// Define ADDER_SELF_CHECK_EN to build the golden-sum checker (out_err, err_count).
module adder_result_collector #(
    parameter int SIZE    = 16,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    input  logic [SIZE-1:0] s,
    input  logic            cout,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE:0]   out_sum,
    output logic [SIZE-1:0] out_a,
    output logic [SIZE-1:0] out_b,
    output logic            out_err,
    output logic            fifo_full,
    output logic [15:0]     drop_count,
    output logic [15:0]     err_count
);
    localparam int AW = $clog2(DEPTH);

    // Shadow of the adder pipeline: tells which s/cout belong to real operands.
    logic            sh_valid [LATENCY];
    logic [SIZE-1:0] sh_a     [LATENCY];
    logic [SIZE-1:0] sh_b     [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < LATENCY; k++) sh_valid[k] <= 1'b0;
        end else begin
            sh_valid[0] <= in_valid;
            for (int unsigned k = 1; k < LATENCY; k++) sh_valid[k] <= sh_valid[k-1];
        end
    end

    always_ff @(posedge clk) begin
        sh_a[0] <= a;
        sh_b[0] <= b;
        for (int unsigned k = 1; k < LATENCY; k++) begin
            sh_a[k] <= sh_a[k-1];
            sh_b[k] <= sh_b[k-1];
        end
    end

    logic          cand;
    logic [SIZE:0] cand_sum;

`ifdef ADDER_SELF_CHECK_EN
    logic          sh_cin [LATENCY];
    logic [SIZE:0] gold;
    logic          cand_err;

    always_ff @(posedge clk) begin
        sh_cin[0] <= cin;
        for (int unsigned k = 1; k < LATENCY; k++) sh_cin[k] <= sh_cin[k-1];
    end

    always_comb begin
        gold     = {1'b0, sh_a[LATENCY-1]} + {1'b0, sh_b[LATENCY-1]}
                 + {{SIZE{1'b0}}, sh_cin[LATENCY-1]};
        cand_err = ({cout, s} != gold);
    end
`else
    logic unused_cin;
    assign unused_cin = cin;
`endif

    always_comb begin
        cand     = sh_valid[LATENCY-1];
        cand_sum = {cout, s};
    end

    // Result FIFO, first-word-fall-through
    logic [SIZE:0]   mem_sum [DEPTH];
    logic [SIZE-1:0] mem_a   [DEPTH];
    logic [SIZE-1:0] mem_b   [DEPTH];
`ifdef ADDER_SELF_CHECK_EN
    logic            mem_err [DEPTH];
`endif
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            full;
    logic            not_empty;
    logic            pop;
    logic            push;

    always_comb begin
        full      = (count == (AW+1)'(DEPTH));
        not_empty = (count != '0);
        pop       = not_empty && out_ready;
        // The adder cannot stall, so a full FIFO only accepts when it frees a slot this edge.
        push      = cand && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_sum[wr_ptr] <= cand_sum;
            mem_a[wr_ptr]   <= sh_a[LATENCY-1];
            mem_b[wr_ptr]   <= sh_b[LATENCY-1];
`ifdef ADDER_SELF_CHECK_EN
            mem_err[wr_ptr] <= cand_err;
`endif
        end
    end

    always_comb begin
        out_valid = not_empty;
        fifo_full = full;
        out_sum   = '0;
        out_a     = '0;
        out_b     = '0;
        out_err   = 1'b0;
        if (not_empty) begin
            out_sum = mem_sum[rd_ptr];
            out_a   = mem_a[rd_ptr];
            out_b   = mem_b[rd_ptr];
`ifdef ADDER_SELF_CHECK_EN
            out_err = mem_err[rd_ptr];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (cand && !push && (drop_count != '1)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

`ifdef ADDER_SELF_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (push && cand_err && (err_count != '1)) begin
            err_count <= err_count + 16'd1;
        end
    end
`else
    always_comb err_count = '0;
`endif

endmodule

// File: tb/tb_adder_result_collector.sv
// Scoreboard bench for adder_result_collector with a behavioural LATENCY-deep adder in front.
// Build with or without ADDER_SELF_CHECK_EN; expectations follow the macro.
`timescale 1ns/1ps
module tb_adder_result_collector;
    localparam int SIZE  = 16;
    localparam int LAT   = 4;
    localparam int DEPTH = 4;
`ifdef ADDER_SELF_CHECK_EN
    localparam logic SC = 1'b1;
`else
    localparam logic SC = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            cin;
    logic            corrupt;
    logic [SIZE-1:0] s;
    logic            cout;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE:0]   out_sum;
    logic [SIZE-1:0] out_a;
    logic [SIZE-1:0] out_b;
    logic            out_err;
    logic            fifo_full;
    logic [15:0]     drop_count;
    logic [15:0]     err_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [SIZE:0]   sum;
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
        logic            err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Free-running adder model; 'corrupt' zeroes s for the op sampled that edge.
    logic [SIZE:0] apipe [LAT];
    always @(posedge clk) begin
        logic [SIZE:0] t;
        t = {1'b0, a} + {1'b0, b} + {{SIZE{1'b0}}, cin};
        if (corrupt) t[SIZE-1:0] = '0;
        apipe[0] <= t;
        for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
    end
    assign {cout, s} = apipe[LAT-1];

    adder_result_collector #(.SIZE(SIZE), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .s(s), .cout(cout), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_a(out_a), .out_b(out_b), .out_err(out_err),
        .fifo_full(fifo_full), .drop_count(drop_count), .err_count(err_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got sum %0h a %0h b %0h, expected no result",
                         out_sum, out_a, out_b);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_sum", 32'(out_sum), 32'(e.sum));
                check("out_a",   32'(out_a),   32'(e.a));
                check("out_b",   32'(out_b),   32'(e.b));
                check("out_err", 32'(out_err), 32'(e.err));
            end
        end
    end

    task automatic issue(input logic [SIZE-1:0] ia, input logic [SIZE-1:0] ib, input logic icin,
                         input logic icorrupt, input logic keep, input logic [SIZE:0] esum,
                         input logic eerr);
        exp_t e;
        @(posedge clk); #1;
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        cin      = icin;
        corrupt  = icorrupt;
        if (keep) begin
            e.sum = esum;
            e.a   = ia;
            e.b   = ib;
            e.err = eerr;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            corrupt  = 1'b0;
            a        = '0;
            b        = '0;
            cin      = 1'b0;
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(out_valid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; corrupt = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and idle stream
        @(negedge clk);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_fifo_full",  32'(fifo_full),  32'd0);
        check("rst_out_sum",    32'(out_sum),    32'd0);
        check("rst_out_a",      32'(out_a),      32'd0);
        check("rst_out_b",      32'(out_b),      32'd0);
        check("rst_out_err",    32'(out_err),    32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        check("rst_err_count",  32'(err_count),  32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_out_valid", 32'(out_valid), 32'd0);
        end
        check("idle_drop_count", 32'(drop_count), 32'd0);
        check("idle_err_count",  32'(err_count),  32'd0);

        // Single op: out_valid exactly LAT+1 cycles after in_valid, for one cycle
        issue(16'd14, 16'd11, 1'b0, 1'b0, 1'b1, 17'd25, 1'b0);
        idle(1);
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            check("latency_early", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        check("latency_exact", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("latency_single", 32'(out_valid), 32'd0);

        // Back-to-back carry-out cases, no bubble between results
        issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 17'h1FFFE, 1'b0);
        issue(16'hFFFF, 16'h8000, 1'b0, 1'b0, 1'b1, 17'h17FFF, 1'b0);
        idle(1);
        wait_valid("b2b_first", 20);
        @(negedge clk);
        check("b2b_no_gap", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("b2b_end", 32'(out_valid), 32'd0);

        // Overflow: six ops into a 4-deep FIFO with the consumer stalled
        @(posedge clk); #1 out_ready = 1'b0;
        for (int i = 1; i <= 6; i++)
            issue(SIZE'(i), SIZE'(i), 1'b0, 1'b0, (i <= 4), (SIZE+1)'(2 * i), 1'b0);
        idle(LAT + 3);
        @(negedge clk);
        check("ovf_fifo_full",  32'(fifo_full),  32'd1);
        check("ovf_drop_count", 32'(drop_count), 32'd2);
        check("ovf_out_valid",  32'(out_valid),  32'd1);
        check("ovf_head_sum",   32'(out_sum),    32'd2);
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_fifo_full", 32'(fifo_full), 32'd0);

        // Corrupted sum: flagged only when the self-check is built
        issue(16'd300, 16'd300, 1'b0, 1'b1, 1'b1, 17'h00000, SC);
        issue(16'd7,   16'd8,   1'b1, 1'b0, 1'b1, 17'd16,    1'b0);
        idle(LAT + 5);
        @(negedge clk);
        check("err_count", 32'(err_count), SC ? 32'd1 : 32'd0);
        check("err_drop_count_held", 32'(drop_count), 32'd2);

        // Reset with ops in flight discards them and clears counters
        issue(16'd1, 16'd2, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        issue(16'd3, 16'd4, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        issue(16'd5, 16'd6, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("flush_out_valid", 32'(out_valid), 32'd0);
        end
        check("flush_drop_count", 32'(drop_count), 32'd0);
        check("flush_err_count",  32'(err_count),  32'd0);
        check("flush_fifo_full",  32'(fifo_full),  32'd0);
        check("scoreboard_empty", 32'(sb.size()),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
